// File: rtl/uart_tx_frame_if.sv
// Parallel-byte request side and serial-line status of the UART transmit framer.
// The master drives the byte request; the slave (framer) returns the serial line and Busy.
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) ();
  logic [DATA_WIDTH-1:0]     P_DATA;
  logic                      Data_Valid;
  logic                      PAR_EN;
  logic                      PAR_TYP;
  logic [PRESCALE_WIDTH-1:0] Prescale;
  logic                      TX_OUT;
  logic                      Busy;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
    input  TX_OUT, Busy
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
    output TX_OUT, Busy
  );
endinterface

// File: rtl/uart_tx_frame.sv
// UART TX framer: start, LSB-first data, optional parity, stop; each bit held Prescale CLK cycles.
// Start bit appears 1 cycle after accept; requests while Busy are dropped (no queue).
module uart_tx_frame #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic            CLK,
  input  logic            RST,
  uart_tx_frame_if.slave  bus
);
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                    r_state;
  logic [PRESCALE_WIDTH-1:0] r_edge_cnt;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic [BIT_W-1:0]          r_bit_cnt;
  logic [DATA_WIDTH-1:0]     r_data;
  logic                      r_par_en;
  logic                      r_par_typ;
  logic                      r_tx;
  logic                      r_busy;

  // Modulo subtraction: a latched Prescale of 0 yields a 2^PRESCALE_WIDTH cycle bit.
  logic [PRESCALE_WIDTH-1:0] w_last_edge;
  logic                      w_bit_done;
  logic [BIT_W-1:0]          w_next_bit;
  logic                      w_parity;

  assign w_last_edge = r_prescale - PRESCALE_WIDTH'(1);
  assign w_bit_done  = (r_edge_cnt == w_last_edge);
  assign w_next_bit  = r_bit_cnt + BIT_W'(1);
  assign w_parity    = r_par_typ ? ~^r_data : ^r_data;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_prescale <= '0;
      r_data     <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else if (r_state == IDLE) begin
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      if (bus.Data_Valid) begin
        r_data     <= bus.P_DATA;
        r_par_en   <= bus.PAR_EN;
        r_par_typ  <= bus.PAR_TYP;
        r_prescale <= bus.Prescale;
        r_state    <= START;
        r_tx       <= 1'b0;
        r_busy     <= 1'b1;
      end
    end else if (!w_bit_done) begin
      r_edge_cnt <= r_edge_cnt + PRESCALE_WIDTH'(1);
    end else begin
      // Bit period complete: the registered line value for the next bit is set here.
      r_edge_cnt <= '0;
      case (r_state)
        START: begin
          r_state   <= DATA;
          r_bit_cnt <= '0;
          r_tx      <= r_data[0];
        end
        DATA: begin
          if (r_bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
            if (r_par_en) begin
              r_state <= PARITY;
              r_tx    <= w_parity;
            end else begin
              r_state <= STOP;
              r_tx    <= 1'b1;
            end
          end else begin
            r_bit_cnt <= w_next_bit;
            r_tx      <= r_data[w_next_bit];
          end
        end
        PARITY: begin
          r_state <= STOP;
          r_tx    <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.TX_OUT = r_tx;
  assign bus.Busy   = r_busy;
endmodule
